// File: rtl/i3c_sdr_bus_cond_detect.sv
// ---------------------------------------------------------------------------
// i3c_sdr_bus_cond_detect
//
// Front end for the SDR broadcast state machine. The block does five things:
//   - It synchronises the raw SCL and SDA pins into the clk domain.
//   - It produces SCL edge strobes.
//   - It produces START / repeated-START / STOP strobes.
//   - It decodes the address header that follows every START or Sr.
//   - It flags an ACKed broadcast write header with i3c_sdr_cmd_detect. The next
//     stage then shifts the CCC byte on the scl_rising strobes that follow.
//
// Parameters
//   SYNC_STAGES  flops per pin synchroniser (>= 2)
//   BCAST_ADDR   broadcast address recognised in the header
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   scl_in, sda_in      raw bus pins
//   scl_sync, sda_sync  synchronised pins (last synchroniser stage)
//   scl_rising/falling  1-clk SCL edge strobes
//   start_detect        1-clk strobe for START or Sr
//   rstart_detect       1-clk strobe for Sr (a START while the bus is busy)
//   stop_detected       1-clk strobe for STOP
//   bus_busy            high from START until STOP
//   hdr_addr, hdr_rnw   last captured header address and RnW bit
//   hdr_nack            1-clk strobe, header ACK slot sampled SDA=1
//   i3c_sdr_cmd_detect  1-clk strobe, ACKed broadcast write header
//
// All strobes are combinational from the synchronised pins and the registered
// state. They therefore appear SYNC_STAGES+1 clk periods after a pin
// transition. The period in which the pin moves counts as the first.
// ---------------------------------------------------------------------------
module i3c_sdr_bus_cond_detect #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] BCAST_ADDR  = 7'h7E
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_sync,
  output logic       sda_sync,
  output logic       scl_rising,
  output logic       scl_falling,
  output logic       start_detect,
  output logic       rstart_detect,
  output logic       stop_detected,
  output logic       bus_busy,
  output logic [6:0] hdr_addr,
  output logic       hdr_rnw,
  output logic       hdr_nack,
  output logic       i3c_sdr_cmd_detect
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    ACK     = 3'd2,
    ACK_END = 3'd3,
    PAYLOAD = 3'd4
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sr;
  logic [SYNC_STAGES-1:0] sda_sr;
  logic                   prev_scl;
  logic                   prev_sda;
  logic [3:0]             bit_cnt;
  logic [6:0]             shift_sr;

  logic scl_rise_raw;
  logic scl_fall_raw;
  logic start_raw;
  logic stop_raw;

  assign scl_sync = scl_sr[SYNC_STAGES-1];
  assign sda_sync = sda_sr[SYNC_STAGES-1];

  // Both START and STOP require SCL to be high in both samples. An SDA change
  // in the same clk as an SCL edge therefore produces only the SCL edge strobe.
  assign scl_rise_raw = ~prev_scl & scl_sync;
  assign scl_fall_raw = prev_scl & ~scl_sync;
  assign start_raw    = prev_sda & ~sda_sync & prev_scl & scl_sync;
  assign stop_raw     = ~prev_sda & sda_sync & prev_scl & scl_sync;

  // Strobes are gated by rst, so the cycle in which reset is sampled
  // never emits a pulse from an aborted frame.
  assign scl_rising         = ~rst & scl_rise_raw;
  assign scl_falling        = ~rst & scl_fall_raw;
  assign start_detect       = ~rst & start_raw;
  assign stop_detected      = ~rst & stop_raw;
  assign rstart_detect      = ~rst & start_raw & bus_busy;
  assign hdr_nack           = ~rst & (state == ACK) & scl_rise_raw & sda_sync;
  // ACK_END is entered only after a low ACK. The falling edge that closes the
  // ACK slot cannot coincide with a START or STOP, because both need SCL held high.
  assign i3c_sdr_cmd_detect = ~rst & (state == ACK_END) & scl_fall_raw &
                              (hdr_addr == BCAST_ADDR) & ~hdr_rnw;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sr   <= '1;
      sda_sr   <= '1;
      prev_scl <= 1'b1;
      prev_sda <= 1'b1;
      bus_busy <= 1'b0;
      hdr_addr <= 7'd0;
      hdr_rnw  <= 1'b0;
      bit_cnt  <= 4'd0;
      shift_sr <= 7'd0;
      state    <= IDLE;
    end else begin
      scl_sr   <= {scl_sr[SYNC_STAGES-2:0], scl_in};
      sda_sr   <= {sda_sr[SYNC_STAGES-2:0], sda_in};
      prev_scl <= scl_sync;
      prev_sda <= sda_sync;

      if (start_raw) begin
        bus_busy <= 1'b1;
      end else if (stop_raw) begin
        bus_busy <= 1'b0;
      end

      if (stop_raw) begin
        state <= IDLE;
      end else if (start_raw) begin
        state    <= ADDR;
        bit_cnt  <= 4'd0;
        shift_sr <= 7'd0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: begin
            if (scl_rise_raw) begin
              shift_sr <= {shift_sr[5:0], sda_sync};
              bit_cnt  <= bit_cnt + 4'd1;
              // On the 8th bit, shift_sr still holds the seven address bits.
              // The bit being sampled now is RnW.
              if (bit_cnt == 4'd7) begin
                hdr_addr <= shift_sr;
                hdr_rnw  <= sda_sync;
                state    <= ACK;
              end
            end
          end
          ACK: begin
            if (scl_rise_raw) begin
              state <= sda_sync ? PAYLOAD : ACK_END;
            end
          end
          ACK_END: begin
            if (scl_fall_raw) begin
              state <= PAYLOAD;
            end
          end
          PAYLOAD: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i3c_sdr_bus_cond_detect.sv
// ---------------------------------------------------------------------------
// Directed testbench for i3c_sdr_bus_cond_detect.
// Pins are driven on the falling clk edge and outputs are sampled on the
// falling edge. Each bus phase is held for 4 clk, which is longer than the
// synchroniser latency. A monitor counts every strobe so that scenario tasks
// can compare counter deltas against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_i3c_sdr_bus_cond_detect;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_in;
  logic       sda_in;
  logic       scl_sync;
  logic       sda_sync;
  logic       scl_rising;
  logic       scl_falling;
  logic       start_detect;
  logic       rstart_detect;
  logic       stop_detected;
  logic       bus_busy;
  logic [6:0] hdr_addr;
  logic       hdr_rnw;
  logic       hdr_nack;
  logic       i3c_sdr_cmd_detect;

  int n_checks = 0;
  int n_fail   = 0;

  int cnt_start   = 0;
  int cnt_rstart  = 0;
  int cnt_stop    = 0;
  int cnt_cmd     = 0;
  int cnt_nack    = 0;
  int cnt_cmd_bad = 0;

  i3c_sdr_bus_cond_detect dut (
    .clk                (clk),
    .rst                (rst),
    .scl_in             (scl_in),
    .sda_in             (sda_in),
    .scl_sync           (scl_sync),
    .sda_sync           (sda_sync),
    .scl_rising         (scl_rising),
    .scl_falling        (scl_falling),
    .start_detect       (start_detect),
    .rstart_detect      (rstart_detect),
    .stop_detected      (stop_detected),
    .bus_busy           (bus_busy),
    .hdr_addr           (hdr_addr),
    .hdr_rnw            (hdr_rnw),
    .hdr_nack           (hdr_nack),
    .i3c_sdr_cmd_detect (i3c_sdr_cmd_detect)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Strobe monitor. A cmd pulse must land on an SCL falling edge and never on
  // a START or STOP strobe.
  always @(negedge clk) begin
    if (start_detect)       cnt_start++;
    if (rstart_detect)      cnt_rstart++;
    if (stop_detected)      cnt_stop++;
    if (hdr_nack)           cnt_nack++;
    if (i3c_sdr_cmd_detect) cnt_cmd++;
    if (i3c_sdr_cmd_detect && (!scl_falling || start_detect || stop_detected))
      cnt_cmd_bad++;
  end

  // Driver tasks
  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_scl(input logic v);
    scl_in = v;
    hold(4);
  endtask

  task automatic set_sda(input logic v);
    sda_in = v;
    hold(4);
  endtask

  task automatic send_start;
    set_sda(1'b1);
    set_scl(1'b1);
    set_sda(1'b0);
  endtask

  task automatic send_bit(input logic b);
    set_scl(1'b0);
    set_sda(b);
    set_scl(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
  endtask

  // ACK slot: SCL low, SDA = a, SCL high (sampled), SCL low again.
  task automatic ack_slot(input logic a);
    send_bit(a);
    set_scl(1'b0);
  endtask

  task automatic send_stop;
    set_scl(1'b0);
    set_sda(1'b0);
    set_scl(1'b1);
    set_sda(1'b1);
  endtask

  // Scenarios
  task automatic test_reset;
    rst = 1'b1; scl_in = 1'b1; sda_in = 1'b1;
    hold(3);
    n_checks++; if (scl_sync !== 1'b1) begin n_fail++; $display("FAIL reset_scl_sync: got %b want 1", scl_sync); end
    n_checks++; if (sda_sync !== 1'b1) begin n_fail++; $display("FAIL reset_sda_sync: got %b want 1", sda_sync); end
    n_checks++; if (bus_busy !== 1'b0) begin n_fail++; $display("FAIL reset_bus_busy: got %b want 0", bus_busy); end
    n_checks++; if (hdr_addr !== 7'h00) begin n_fail++; $display("FAIL reset_hdr_addr: got %h want 00", hdr_addr); end
    n_checks++; if (hdr_rnw !== 1'b0) begin n_fail++; $display("FAIL reset_hdr_rnw: got %b want 0", hdr_rnw); end
    n_checks++; if ({scl_rising, scl_falling, start_detect, rstart_detect, stop_detected, hdr_nack, i3c_sdr_cmd_detect} !== 7'b0)
      begin n_fail++; $display("FAIL reset_pulses: got %b want 0000000", {scl_rising, scl_falling, start_detect, rstart_detect, stop_detected, hdr_nack, i3c_sdr_cmd_detect}); end
    rst = 1'b0;
    hold(4);
  endtask

  task automatic test_latency;
    // The pin moves at a negedge. The strobe is expected in the third period
    // counted from that change, i.e. it is visible only at the 2nd following
    // negedge.
    sda_in = 1'b0;
    hold(1);
    n_checks++; if (start_detect !== 1'b0) begin n_fail++; $display("FAIL lat_start_early: got %b want 0", start_detect); end
    hold(1);
    n_checks++; if (start_detect !== 1'b1) begin n_fail++; $display("FAIL lat_start_on: got %b want 1", start_detect); end
    n_checks++; if (rstart_detect !== 1'b0) begin n_fail++; $display("FAIL lat_rstart_idle: got %b want 0", rstart_detect); end
    hold(1);
    n_checks++; if (start_detect !== 1'b0) begin n_fail++; $display("FAIL lat_start_width: got %b want 0", start_detect); end
    n_checks++; if (bus_busy !== 1'b1) begin n_fail++; $display("FAIL lat_busy_set: got %b want 1", bus_busy); end
    hold(2);
    sda_in = 1'b1;
    hold(1);
    n_checks++; if (stop_detected !== 1'b0) begin n_fail++; $display("FAIL lat_stop_early: got %b want 0", stop_detected); end
    hold(1);
    n_checks++; if (stop_detected !== 1'b1) begin n_fail++; $display("FAIL lat_stop_on: got %b want 1", stop_detected); end
    hold(1);
    n_checks++; if (stop_detected !== 1'b0) begin n_fail++; $display("FAIL lat_stop_width: got %b want 0", stop_detected); end
    n_checks++; if (bus_busy !== 1'b0) begin n_fail++; $display("FAIL lat_busy_clr: got %b want 0", bus_busy); end
    hold(2);
  endtask

  task automatic test_simultaneous;
    int s0, p0;
    s0 = cnt_start; p0 = cnt_stop;
    scl_in = 1'b0; sda_in = 1'b0;
    hold(2);
    n_checks++; if (scl_falling !== 1'b1) begin n_fail++; $display("FAIL sim_fall_edge: got %b want 1", scl_falling); end
    n_checks++; if (start_detect !== 1'b0) begin n_fail++; $display("FAIL sim_no_start: got %b want 0", start_detect); end
    hold(2);
    scl_in = 1'b1; sda_in = 1'b1;
    hold(2);
    n_checks++; if (scl_rising !== 1'b1) begin n_fail++; $display("FAIL sim_rise_edge: got %b want 1", scl_rising); end
    n_checks++; if (stop_detected !== 1'b0) begin n_fail++; $display("FAIL sim_no_stop: got %b want 0", stop_detected); end
    hold(3);
    n_checks++; if ((cnt_start - s0) !== 0 || (cnt_stop - p0) !== 0)
      begin n_fail++; $display("FAIL sim_cond_count: got start %0d stop %0d want 0 0", cnt_start - s0, cnt_stop - p0); end
  endtask

  task automatic test_bcast_write;
    int c0, n0, p0;
    c0 = cnt_cmd; n0 = cnt_nack; p0 = cnt_stop;
    send_start;
    send_byte(8'hFC);
    ack_slot(1'b0);
    n_checks++; if ((cnt_cmd - c0) !== 1) begin n_fail++; $display("FAIL bw_cmd_count: got %0d want 1", cnt_cmd - c0); end
    n_checks++; if (hdr_addr !== 7'h7E) begin n_fail++; $display("FAIL bw_hdr_addr: got %h want 7e", hdr_addr); end
    n_checks++; if (hdr_rnw !== 1'b0) begin n_fail++; $display("FAIL bw_hdr_rnw: got %b want 0", hdr_rnw); end
    n_checks++; if ((cnt_nack - n0) !== 0) begin n_fail++; $display("FAIL bw_nack_count: got %0d want 0", cnt_nack - n0); end
    n_checks++; if (bus_busy !== 1'b1) begin n_fail++; $display("FAIL bw_busy: got %b want 1", bus_busy); end
    send_stop;
    n_checks++; if ((cnt_stop - p0) !== 1 || bus_busy !== 1'b0)
      begin n_fail++; $display("FAIL bw_stop: got stops %0d busy %b want 1 0", cnt_stop - p0, bus_busy); end
  endtask

  task automatic test_bcast_read;
    int c0;
    c0 = cnt_cmd;
    send_start;
    send_byte(8'hFD);
    ack_slot(1'b0);
    n_checks++; if ((cnt_cmd - c0) !== 0) begin n_fail++; $display("FAIL br_cmd_count: got %0d want 0", cnt_cmd - c0); end
    n_checks++; if (hdr_addr !== 7'h7E) begin n_fail++; $display("FAIL br_hdr_addr: got %h want 7e", hdr_addr); end
    n_checks++; if (hdr_rnw !== 1'b1) begin n_fail++; $display("FAIL br_hdr_rnw: got %b want 1", hdr_rnw); end
    send_stop;
  endtask

  task automatic test_nack;
    int c0, n0;
    c0 = cnt_cmd; n0 = cnt_nack;
    send_start;
    send_byte(8'hFC);
    ack_slot(1'b1);
    n_checks++; if ((cnt_nack - n0) !== 1) begin n_fail++; $display("FAIL nk_nack_count: got %0d want 1", cnt_nack - n0); end
    n_checks++; if ((cnt_cmd - c0) !== 0) begin n_fail++; $display("FAIL nk_cmd_count: got %0d want 0", cnt_cmd - c0); end
    n_checks++; if (hdr_addr !== 7'h7E || hdr_rnw !== 1'b0)
      begin n_fail++; $display("FAIL nk_hdr: got %h/%b want 7e/0", hdr_addr, hdr_rnw); end
    send_stop;
  endtask

  task automatic test_back_to_back;
    int c0, r0;
    c0 = cnt_cmd; r0 = cnt_rstart;
    send_start;
    send_byte(8'hA4);
    ack_slot(1'b0);
    n_checks++; if (hdr_addr !== 7'h52 || hdr_rnw !== 1'b0)
      begin n_fail++; $display("FAIL b2b_hdr1: got %h/%b want 52/0", hdr_addr, hdr_rnw); end
    n_checks++; if ((cnt_cmd - c0) !== 0) begin n_fail++; $display("FAIL b2b_cmd_first: got %0d want 0", cnt_cmd - c0); end
    n_checks++; if ((cnt_rstart - r0) !== 0) begin n_fail++; $display("FAIL b2b_rstart_first: got %0d want 0", cnt_rstart - r0); end
    send_start;
    n_checks++; if ((cnt_rstart - r0) !== 1) begin n_fail++; $display("FAIL b2b_rstart_sr: got %0d want 1", cnt_rstart - r0); end
    send_byte(8'hFC);
    ack_slot(1'b0);
    n_checks++; if (hdr_addr !== 7'h7E) begin n_fail++; $display("FAIL b2b_hdr2: got %h want 7e", hdr_addr); end
    n_checks++; if ((cnt_cmd - c0) !== 1) begin n_fail++; $display("FAIL b2b_cmd_total: got %0d want 1", cnt_cmd - c0); end
    send_stop;
  endtask

  task automatic test_short_stop;
    int c0, p0;
    c0 = cnt_cmd; p0 = cnt_stop;
    send_start;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_stop;
    n_checks++; if ((cnt_stop - p0) !== 1) begin n_fail++; $display("FAIL ss_stop_count: got %0d want 1", cnt_stop - p0); end
    n_checks++; if (bus_busy !== 1'b0) begin n_fail++; $display("FAIL ss_busy: got %b want 0", bus_busy); end
    n_checks++; if (hdr_addr !== 7'h7E || hdr_rnw !== 1'b0)
      begin n_fail++; $display("FAIL ss_hdr_kept: got %h/%b want 7e/0", hdr_addr, hdr_rnw); end
    n_checks++; if ((cnt_cmd - c0) !== 0) begin n_fail++; $display("FAIL ss_cmd_count: got %0d want 0", cnt_cmd - c0); end
  endtask

  task automatic test_reset_mid_frame;
    int c0, n0, r0;
    c0 = cnt_cmd; n0 = cnt_nack; r0 = cnt_rstart;
    send_start;
    send_byte(8'hFC);
    set_scl(1'b0);
    set_sda(1'b0);
    rst = 1'b1;
    hold(1);
    n_checks++; if (bus_busy !== 1'b0 || hdr_addr !== 7'h00 || hdr_rnw !== 1'b0)
      begin n_fail++; $display("FAIL rm_regs: got busy %b addr %h rnw %b want 0 00 0", bus_busy, hdr_addr, hdr_rnw); end
    n_checks++; if (scl_sync !== 1'b1 || sda_sync !== 1'b1)
      begin n_fail++; $display("FAIL rm_sync: got %b%b want 11", scl_sync, sda_sync); end
    n_checks++; if ({scl_rising, scl_falling, start_detect, rstart_detect, stop_detected, hdr_nack, i3c_sdr_cmd_detect} !== 7'b0)
      begin n_fail++; $display("FAIL rm_pulses: got %b want 0000000", {scl_rising, scl_falling, start_detect, rstart_detect, stop_detected, hdr_nack, i3c_sdr_cmd_detect}); end
    hold(1);
    rst = 1'b0;
    hold(4);
    set_scl(1'b1);
    set_scl(1'b0);
    n_checks++; if ((cnt_cmd - c0) !== 0 || (cnt_nack - n0) !== 0)
      begin n_fail++; $display("FAIL rm_no_pulse: got cmd %0d nack %0d want 0 0", cnt_cmd - c0, cnt_nack - n0); end
    send_start;
    send_byte(8'hFC);
    ack_slot(1'b0);
    n_checks++; if ((cnt_cmd - c0) !== 1) begin n_fail++; $display("FAIL rm_cmd_after: got %0d want 1", cnt_cmd - c0); end
    n_checks++; if ((cnt_rstart - r0) !== 0) begin n_fail++; $display("FAIL rm_rstart: got %0d want 0", cnt_rstart - r0); end
    send_stop;
  endtask

  task automatic test_cmd_alignment;
    n_checks++; if (cnt_cmd_bad !== 0) begin n_fail++; $display("FAIL cmd_alignment: got %0d bad pulses want 0", cnt_cmd_bad); end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_simultaneous;
    test_bcast_write;
    test_bcast_read;
    test_nack;
    test_back_to_back;
    test_short_stop;
    test_reset_mid_frame;
    test_cmd_alignment;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
